// File: rtl/ps2_keyboard_decoder_if.sv
// Pin-side and game-side signals of the PS/2 keyboard decoder.
// The master drives the PS/2 pins. The slave (the decoder) drives the key outputs.
interface ps2_keyboard_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       extended;
  logic       new_key_strobe;
  logic       frame_error;

  modport master (
    output ps2_clk, ps2_data,
    input  keycode, extended, new_key_strobe, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keycode, extended, new_key_strobe, frame_error
  );
endinterface

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 device-to-host receiver: synchronizes and filters the pins, deframes 11-bit frames,
// and interprets E0/F0 prefixes so that only make codes raise new_key_strobe.
module ps2_keyboard_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_keyboard_decoder_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_d, fe_q, fe_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d, key_q, key_d;
  logic          par_q, par_d, ext_q, ext_d, brk_q, brk_d;
  logic          extd_q, extd_d, stb_q, stb_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          din;

  assign din = dat_sync_q[1];

  // The filtered clock flips only after FILTER_LEN consecutive samples that disagree with it.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fe_d       = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
        fe_d   = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    key_d    = key_q;
    extd_d   = extd_q;
    stb_d    = 1'b0;
    err_d    = 1'b0;
    tmo_d    = '0;
    if (fe_q) begin
      case (state_q)
        IDLE: if (!din) begin
          state_d  = DATA;
          bitcnt_d = 3'd0;
        end
        DATA: begin
          shift_d  = {din, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (din && (^{shift_q, par_q})) begin
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              // A break sequence swallows the code it releases.
              if (!brk_q) begin
                key_d  = shift_q;
                extd_d = ext_q;
                stb_d  = 1'b1;
              end
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fe_q       <= 1'b0;
      state_q    <= IDLE;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_q      <= 8'h00;
      extd_q     <= 1'b0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
      dat_sync_q <= {dat_sync_q[0], bus.ps2_data};
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      fe_q       <= fe_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_q      <= key_d;
      extd_q     <= extd_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.keycode        = key_q;
  assign bus.extended       = extd_q;
  assign bus.new_key_strobe = stb_q;
  assign bus.frame_error    = err_q;
endmodule
